// File: rtl/data_memory_ctrl.sv
// Byte-organised data memory for the SEQ processor.
// Each 8-byte little-endian access runs as eight single-byte beats on an
// internal byte-wide RAM. The core is stalled with mem_busy while a transfer
// runs. Out-of-range or conflicting requests finish at once with dmem_error.
module data_memory_ctrl #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_data,
    output logic [63:0] valM,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        dmem_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Highest legal start address. Every byte of the access must lie inside the RAM.
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

    state_t         state_r;
    logic [2:0]     beat_r;
    logic           is_write_r;
    logic [AW-1:0]  addr_r;
    logic [63:0]    data_r;
    logic [63:0]    rdbuf_r;

    logic [7:0]     ram_r [MEM_BYTES];

    logic [AW-1:0]  byte_idx_s;
    logic [7:0]     ram_rd_s;
    logic [7:0]     wr_byte_s;
    logic [63:0]    rdbuf_next_s;
    logic           ram_we_s;
    logic           req_one_s;
    logic           req_both_s;
    logic           addr_bad_s;

    // The start address is at most MEM_BYTES-8, so addr+beat never wraps.
    assign byte_idx_s = addr_r + AW'(beat_r);
    assign ram_rd_s   = ram_r[byte_idx_s];
    assign ram_we_s   = (state_r == ACCESS) && is_write_r;
    assign req_one_s  = mem_read ^ mem_write;
    assign req_both_s = mem_read & mem_write;
    assign addr_bad_s = (mem_addr > LAST_ADDR);

    // Select the write byte for this beat and merge the read byte into the read buffer.
    always_comb begin
        wr_byte_s    = data_r[{beat_r, 3'b000} +: 8];
        rdbuf_next_s = rdbuf_r;
        rdbuf_next_s[{beat_r, 3'b000} +: 8] = ram_rd_s;
    end

    // Byte-wide RAM write port. Contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[byte_idx_s] <= wr_byte_s;
        end
    end

    // Transfer sequencer with registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            beat_r     <= 3'd0;
            is_write_r <= 1'b0;
            addr_r     <= '0;
            data_r     <= 64'd0;
            rdbuf_r    <= 64'd0;
            valM       <= 64'd0;
            mem_busy   <= 1'b0;
            mem_done   <= 1'b0;
            dmem_error <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    mem_done   <= 1'b0;
                    dmem_error <= 1'b0;
                    mem_busy   <= 1'b0;
                    if (req_both_s || (req_one_s && addr_bad_s)) begin
                        // Rejected request: finish in one cycle with no RAM access.
                        is_write_r <= 1'b0;
                        state_r    <= DONE;
                        mem_done   <= 1'b1;
                        dmem_error <= 1'b1;
                    end else if (req_one_s) begin
                        is_write_r <= mem_write;
                        addr_r     <= mem_addr[AW-1:0];
                        data_r     <= mem_data;
                        beat_r     <= 3'd0;
                        state_r    <= ACCESS;
                        mem_busy   <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!is_write_r) begin
                        rdbuf_r <= rdbuf_next_s;
                    end
                    beat_r <= beat_r + 3'd1;
                    if (beat_r == 3'd7) begin
                        // The last byte goes straight into valM so it appears together with mem_done.
                        if (!is_write_r) begin
                            valM <= rdbuf_next_s;
                        end
                        state_r  <= DONE;
                        mem_busy <= 1'b0;
                        mem_done <= 1'b1;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    mem_busy   <= 1'b0;
                    mem_done   <= 1'b0;
                    dmem_error <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    beat_r     <= 3'd0;
                    mem_busy   <= 1'b0;
                    mem_done   <= 1'b0;
                    dmem_error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Byte-organised data memory for the SEQ processor. It consumes the memory stage's access request (mem_read, mem_write, mem_addr, mem_data) and performs each 8-byte little-endian access as eight sequential single-byte beats on an internal byte-wide RAM. It returns valM for reads, stalls the core with mem_busy while a transfer runs, and reports out-of-range or illegal requests on dmem_error.

Parameters:
MEM_BYTES, 1024, RAM size in bytes (power of two, >= 8)
AW, 10, internal RAM index width, log2(MEM_BYTES)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
mem_read  input  1  read request level from memory stage
mem_write  input  1  write request level from memory stage
mem_addr  input  64  byte address of 8-byte access (any alignment)
mem_data  input  64  write data, little-endian
valM  output  64  read data, valid from mem_done of a read until the next read completes
mem_busy  output  1  transfer in progress; core must hold its request stable
mem_done  output  1  one-cycle completion pulse
dmem_error  output  1  error flag, valid in the mem_done cycle

Behaviour:
- FSM states: IDLE, ACCESS, DONE. The internal state register, beat counter, and output registers reset asynchronously on rst=0. RAM contents are not reset.
- Reset values: valM=0, mem_busy=0, mem_done=0, dmem_error=0, state=IDLE, beat=0.
- IDLE: at each rising edge, sample the request.
  - Neither mem_read nor mem_write asserted: stay in IDLE.
  - Both asserted: go to DONE with dmem_error=1. No RAM access.
  - Exactly one asserted and mem_addr > MEM_BYTES-8 (unsigned, full 64-bit compare): go to DONE with dmem_error=1. No RAM access. A request spanning the end of memory is an error.
  - Otherwise: latch the operation, mem_addr[AW-1:0] and mem_data; set beat=0; go to ACCESS.
- ACCESS: mem_busy=1. On each edge, transfer byte index addr+beat.
  - Write: RAM[addr+beat] <= data[8*beat+7 : 8*beat].
  - Read: rdbuf[8*beat+7 : 8*beat] <= RAM[addr+beat].
  - beat increments each edge. After the edge with beat=7, go to DONE.
  - Exactly 8 edges are spent in ACCESS. Request inputs are ignored in this state.
- DONE: mem_busy=0, mem_done=1 for exactly one cycle.
  - Read: valM <= rdbuf, updated on entry to DONE so it is visible in the same cycle as mem_done.
  - Write or error: valM is unchanged.
  - Next edge returns to IDLE; dmem_error clears.
- Latency: request accepted at edge E; mem_busy is high for cycles E+1..E+8; mem_done is high in cycle E+9. For the error path, mem_done is high in cycle E+1.
- Back-to-back: the first IDLE cycle after DONE samples the request again. Upstream changes its request on observing mem_done. A request still held is treated as a new access.
- Misaligned addresses are legal. The byte order is always little-endian relative to mem_addr.
- Reset mid-ACCESS: bytes already written stay written, remaining bytes are untouched, all outputs return to reset values immediately, and no mem_done is produced.
- mem_busy, mem_done and dmem_error are registered outputs with no combinational path from the inputs.

Test Plan:
- Write 0x0123456789ABCDEF at 0x100, then read 0x100: mem_done 9 cycles after each acceptance; valM=0x0123456789ABCDEF; RAM[0x100]=0xEF, RAM[0x107]=0x01.
- Misaligned: write 0x1122334455667788 at 0x103, then read 0x100: valM=0x4455667788xxxxxx, where the lower three bytes hold the prior contents of 0x100..0x102.
- Boundary: write/read at MEM_BYTES-8 succeeds with dmem_error=0. Read at MEM_BYTES-7 gives mem_done one cycle after acceptance with dmem_error=1, valM unchanged, mem_busy never high.
- mem_read=1 and mem_write=1 together at 0x0: dmem_error=1 with mem_done, RAM[0..7] unchanged.
- Write 0xFFFFFFFFFFFFFFFF at 0x200 over zeroed RAM, then drop rst to 0 after 4 ACCESS edges: outputs go to 0 asynchronously, no mem_done. A subsequent read of 0x200 returns 0x00000000FFFFFFFF.
- Two back-to-back reads of 0x100 and 0x108: the second is accepted in the IDLE cycle after the first mem_done, and each valM is correct on its own mem_done.
